spi_bus_arbiter: RTL and testbench
==================================

Name: spi_bus_arbiter

Overview:
- Shares one physical SPI bus (SCLK, MOSI, MISO, chip selects) between the SPI_MEM engine (program/data memory fetch) and the SPI_PERIPH engine (software byte transfers).
- Uses a level request/grant handshake with default memory priority, a starvation limit for the peripheral, bus turnaround gaps and a hold-timeout watchdog.
- Sits between both engines and the top-level SPI pin muxing; drives the peripheral engine's arbitration-blocked input.

Parameters:
- TURNAROUND_CYCLES, 2, idle cycles (bus fully deasserted) between ownership changes; 0 means no gap.
- STARVE_LIMIT, 4, maximum consecutive memory grants while the peripheral is waiting.
- TIMEOUT_CYCLES, 16'd4096, maximum grant hold before forced revoke; 0 disables the watchdog.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous reset, active low
- mem_req  in  1  memory engine requests the bus (level)
- mem_grant  out  1  memory engine owns the bus
- mem_sclk, mem_mosi  in  1 each  memory engine pin drives
- mem_cs_n  in  2  memory chip selects (active low)
- periph_req  in  1  peripheral engine busy (request, level)
- periph_grant  out  1  peripheral engine owns the bus
- periph_blocked  out  1  equal to ~periph_grant; drives the peripheral engine's blocked input
- periph_sclk, periph_mosi  in  1 each  peripheral engine pin drives
- periph_cs  in  6  peripheral chip selects after polarity is applied
- periph_cs_idle  in  6  deasserted level of each peripheral chip select
- periph_cpol  in  1  idle SCLK level
- bus_sclk, bus_mosi  out  1 each  pad-side SPI clock and data out
- bus_mem_cs_n  out  2  pad-side memory chip selects
- bus_periph_cs  out  6  pad-side peripheral chip selects
- owner  out  2  current owner: 0 = none, 1 = MEM, 2 = PERIPH
- timeout_flag  out  1  sticky; set by a forced revoke
- timeout_clr  in  1  clears timeout_flag

Behaviour:
- States: IDLE, GNT_MEM, GNT_PERIPH, TURN. Reset gives IDLE, both grants 0, owner 0, timeout_flag 0, all counters 0.
- Pin mux is combinational on the registered state:
  - GNT_MEM: bus pins follow the mem_* inputs; peripheral chip selects are held at periph_cs_idle.
  - GNT_PERIPH: bus pins follow the periph_* inputs; bus_mem_cs_n is held at 2'b11.
  - IDLE or TURN: bus_sclk = periph_cpol, bus_mosi = 0, bus_mem_cs_n = 2'b11, bus_periph_cs = periph_cs_idle. These are also the reset values of the pins.
- Grant latency:
  - A request sampled in IDLE raises the grant on the next edge (1 cycle).
  - The grant is held while the request stays high.
- Release:
  - When the owner's request goes low, the grant drops on the next edge.
  - The arbiter then enters TURN for TURNAROUND_CYCLES cycles, or goes straight to IDLE when the parameter is 0.
  - A new grant can only be issued from IDLE.
- Decision in IDLE when both requests are high:
  - MEM wins unless starve_cnt == STARVE_LIMIT; in that case PERIPH wins.
  - starve_cnt increments on each MEM grant issued while periph_req is high.
  - starve_cnt clears on any PERIPH grant, and whenever IDLE sees periph_req low.
  - starve_cnt saturates at STARVE_LIMIT.
- A single requester is always granted, with no fairness delay.
- Watchdog:
  - hold_cnt (16 bit) counts cycles in a GNT state and clears on entry to the state.
  - When hold_cnt reaches TIMEOUT_CYCLES-1 and TIMEOUT_CYCLES != 0, the grant is dropped, timeout_flag is set, and the arbiter enters TURN.
  - The revoked requester is marked stale. It cannot be granted again until its request has been observed low for at least one cycle.
- timeout_clr clears timeout_flag. If timeout_clr coincides with a new timeout in the same cycle, the set wins.
- A request dropping and re-rising within TURN does not shorten TURN.
- At most one grant is high in any cycle; this is an assertion in RTL.
- reset_n asserted mid-transfer: all outputs return to their reset values immediately (asynchronously), including the pin idle levels. There is no attempt to complete the transfer.

Decomposition:
- Package spi_arb_pkg holds:
  - typedef arb_state_t {IDLE, GNT_MEM, GNT_PERIPH, TURN}
  - typedef arb_owner_t {OWN_NONE = 0, OWN_MEM = 1, OWN_PERIPH = 2}
  - constant MEM_CS_IDLE = 2'b11
- Single module; no sub-module required. The watchdog counter stays inline.

Test Plan:
- Lone request: periph_req = 1 at cycle 0 → periph_grant = 1 at cycle 1; bus_periph_cs mirrors periph_cs. Drop the request at cycle 10 → grant 0 at cycle 11, owner 0 for 2 cycles, IDLE at cycle 13.
- Simultaneous request: both requests rise together from reset → mem_grant first. Periph is granted only after mem releases and the 2-cycle turnaround; there is no overlap cycle.
- Starvation: periph_req held high while mem re-requests immediately after each release → 4 mem grants, then the 5th grant goes to PERIPH, and starve_cnt returns to 0.
- Watchdog: TIMEOUT_CYCLES = 16 with mem_req held high → mem_grant drops after 16 cycles and timeout_flag = 1. Mem_req still high → no re-grant. Pulse mem_req low for 1 cycle → grant again after TURN. timeout_clr → flag 0.
- Idle levels: with periph_cpol = 1 and periph_cs_idle = 6'h00 in IDLE → bus_sclk = 1, bus_periph_cs = 0, bus_mem_cs_n = 2'b11, bus_mosi = 0.
- Reset mid-grant: assert reset_n low during GNT_PERIPH → grant 0, owner 0, pins at idle levels in the same cycle; after release, a fresh request is granted in 1 cycle.

Source files
------------

// File: rtl/spi_arb_pkg.sv
// Shared types and constants for the SPI bus arbiter.
package spi_arb_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    GNT_MEM    = 2'd1,
    GNT_PERIPH = 2'd2,
    TURN       = 2'd3
  } arb_state_t;

  typedef enum logic [1:0] {
    OWN_NONE   = 2'd0,
    OWN_MEM    = 2'd1,
    OWN_PERIPH = 2'd2
  } arb_owner_t;

  localparam logic [1:0] MEM_CS_IDLE = 2'b11;

endpackage

// File: rtl/spi_bus_arbiter.sv
// Shares one SPI pin set between the memory-fetch engine and the peripheral engine.
// Level req/grant: a grant rises one cycle after a request is seen in IDLE and holds while req stays high.
module spi_bus_arbiter
  import spi_arb_pkg::*;
#(
  parameter int          TURNAROUND_CYCLES = 2,
  parameter int          STARVE_LIMIT      = 4,
  parameter logic [15:0] TIMEOUT_CYCLES    = 16'd4096
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       mem_req,
  output logic       mem_grant,
  input  logic       mem_sclk,
  input  logic       mem_mosi,
  input  logic [1:0] mem_cs_n,
  input  logic       periph_req,
  output logic       periph_grant,
  output logic       periph_blocked,
  input  logic       periph_sclk,
  input  logic       periph_mosi,
  input  logic [5:0] periph_cs,
  input  logic [5:0] periph_cs_idle,
  input  logic       periph_cpol,
  output logic       bus_sclk,
  output logic       bus_mosi,
  output logic [1:0] bus_mem_cs_n,
  output logic [5:0] bus_periph_cs,
  output logic [1:0] owner,
  output logic       timeout_flag,
  input  logic       timeout_clr,
  output logic [1:0] arb_state
);

  localparam logic [7:0]  TURN_LAST     = 8'(TURNAROUND_CYCLES - 1);
  localparam logic [7:0]  STARVE_MAX    = 8'(STARVE_LIMIT);
  localparam logic [15:0] HOLD_LAST     = TIMEOUT_CYCLES - 16'd1;
  localparam logic        WDOG_ON       = (TIMEOUT_CYCLES != 16'd0);
  localparam arb_state_t  RELEASE_STATE = (TURNAROUND_CYCLES == 0) ? IDLE : TURN;

  arb_state_t  state, state_next;
  arb_owner_t  own;
  logic [7:0]  turn_cnt, turn_next;
  logic [7:0]  starve_cnt, starve_next;
  logic [15:0] hold_cnt, hold_next;
  logic        mem_stale, mem_stale_next;
  logic        periph_stale, periph_stale_next;
  logic        flag_next;
  logic        mem_ok, periph_ok, owner_req, mem_wins;

  // A requester revoked by the watchdog stays ineligible until its request is seen low.
  assign mem_ok    = mem_req & ~mem_stale;
  assign periph_ok = periph_req & ~periph_stale;
  assign owner_req = (state == GNT_MEM) ? mem_req : periph_req;
  assign mem_wins  = mem_ok & (~periph_ok | (starve_cnt != STARVE_MAX));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      turn_cnt     <= '0;
      starve_cnt   <= '0;
      hold_cnt     <= '0;
      mem_stale    <= 1'b0;
      periph_stale <= 1'b0;
      timeout_flag <= 1'b0;
    end else begin
      state        <= state_next;
      turn_cnt     <= turn_next;
      starve_cnt   <= starve_next;
      hold_cnt     <= hold_next;
      mem_stale    <= mem_stale_next;
      periph_stale <= periph_stale_next;
      timeout_flag <= flag_next;
    end
  end

  always_comb begin
    state_next        = state;
    turn_next         = turn_cnt;
    hold_next         = hold_cnt;
    starve_next       = starve_cnt;
    mem_stale_next    = mem_stale & mem_req;
    periph_stale_next = periph_stale & periph_req;
    flag_next         = timeout_flag & ~timeout_clr;
    case (state)
      IDLE: begin
        if (!periph_req) starve_next = '0;
        if (mem_wins) begin
          state_next = GNT_MEM;
          hold_next  = '0;
          if (periph_req && (starve_cnt != STARVE_MAX)) starve_next = starve_cnt + 8'd1;
        end else if (periph_ok) begin
          state_next  = GNT_PERIPH;
          hold_next   = '0;
          starve_next = '0;
        end
      end
      GNT_MEM, GNT_PERIPH: begin
        if (!owner_req) begin
          state_next = RELEASE_STATE;
          turn_next  = '0;
        end else if (WDOG_ON && (hold_cnt == HOLD_LAST)) begin
          // Forced revoke: the flag set overrides a same-cycle clear.
          state_next = RELEASE_STATE;
          turn_next  = '0;
          flag_next  = 1'b1;
          if (state == GNT_MEM) mem_stale_next = 1'b1;
          else                  periph_stale_next = 1'b1;
        end else begin
          hold_next = hold_cnt + 16'd1;
        end
      end
      TURN: begin
        if (turn_cnt == TURN_LAST) begin
          state_next = IDLE;
          turn_next  = '0;
        end else begin
          turn_next = turn_cnt + 8'd1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    own           = OWN_NONE;
    bus_sclk      = periph_cpol;
    bus_mosi      = 1'b0;
    bus_mem_cs_n  = MEM_CS_IDLE;
    bus_periph_cs = periph_cs_idle;
    case (state)
      GNT_MEM: begin
        own          = OWN_MEM;
        bus_sclk     = mem_sclk;
        bus_mosi     = mem_mosi;
        bus_mem_cs_n = mem_cs_n;
      end
      GNT_PERIPH: begin
        own           = OWN_PERIPH;
        bus_sclk      = periph_sclk;
        bus_mosi      = periph_mosi;
        bus_periph_cs = periph_cs;
      end
      default: ;
    endcase
  end

  assign mem_grant      = (state == GNT_MEM);
  assign periph_grant   = (state == GNT_PERIPH);
  assign periph_blocked = ~periph_grant;
  assign owner          = own;
  assign arb_state      = state;

  a_one_grant: assert property (@(posedge clk) disable iff (!reset_n) !(mem_grant && periph_grant));

endmodule

// File: tb/tb_spi_bus_arbiter.sv
// Bench for spi_bus_arbiter: directed scenarios plus random traffic against a behavioural owner/gap model.
module tb_spi_bus_arbiter;
  import spi_arb_pkg::*;

  localparam int TURN_GAP = 2;
  localparam int STARVE   = 4;
  localparam int TOUT     = 16;
  localparam int W        = 18;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       mem_req = 1'b0, mem_sclk = 1'b0, mem_mosi = 1'b0;
  logic [1:0] mem_cs_n = 2'b11;
  logic       periph_req = 1'b0, periph_sclk = 1'b0, periph_mosi = 1'b0;
  logic [5:0] periph_cs = 6'h00, periph_cs_idle = 6'h00;
  logic       periph_cpol = 1'b0, timeout_clr = 1'b0;
  logic       mem_grant, periph_grant, periph_blocked, bus_sclk, bus_mosi, timeout_flag;
  logic [1:0] bus_mem_cs_n, owner, arb_state;
  logic [5:0] bus_periph_cs;

  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_fail = 0;

  // Model: who owns the bus, remaining gap cycles, hold length, starvation count, stale marks.
  int m_owner, m_gap, m_hold, m_starve;
  bit m_stale_mem, m_stale_per, m_flag;

  spi_bus_arbiter #(
    .TURNAROUND_CYCLES(TURN_GAP), .STARVE_LIMIT(STARVE), .TIMEOUT_CYCLES(16'(TOUT))
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .mem_req(mem_req), .mem_grant(mem_grant), .mem_sclk(mem_sclk), .mem_mosi(mem_mosi),
    .mem_cs_n(mem_cs_n),
    .periph_req(periph_req), .periph_grant(periph_grant), .periph_blocked(periph_blocked),
    .periph_sclk(periph_sclk), .periph_mosi(periph_mosi), .periph_cs(periph_cs),
    .periph_cs_idle(periph_cs_idle), .periph_cpol(periph_cpol),
    .bus_sclk(bus_sclk), .bus_mosi(bus_mosi), .bus_mem_cs_n(bus_mem_cs_n),
    .bus_periph_cs(bus_periph_cs), .owner(owner), .timeout_flag(timeout_flag),
    .timeout_clr(timeout_clr), .arb_state(arb_state)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_owner = 0; m_gap = 0; m_hold = 0; m_starve = 0;
    m_stale_mem = 0; m_stale_per = 0; m_flag = 0;
  endtask

  function automatic logic [W-1:0] model_out();
    logic mg, pg, sclk, mosi;
    logic [1:0] st, mcs, own;
    logic [5:0] pcs;
    mg = (m_owner == 1);
    pg = (m_owner == 2);
    own = 2'(m_owner);
    if (mg) st = GNT_MEM;
    else if (pg) st = GNT_PERIPH;
    else if (m_gap > 0) st = TURN;
    else st = IDLE;
    sclk = periph_cpol; mosi = 1'b0; mcs = 2'b11; pcs = periph_cs_idle;
    if (mg) begin sclk = mem_sclk; mosi = mem_mosi; mcs = mem_cs_n; end
    if (pg) begin sclk = periph_sclk; mosi = periph_mosi; pcs = periph_cs; end
    return {mg, pg, ~pg, own, m_flag, sclk, mosi, mcs, pcs, st};
  endfunction

  task automatic model_advance();
    bit req, set_mem, set_per, set_flag, mem_ok, per_ok;
    set_mem = 0; set_per = 0; set_flag = 0;
    if (!reset_n) begin
      model_reset();
      return;
    end
    if (m_owner != 0) begin
      req = (m_owner == 1) ? mem_req : periph_req;
      if (!req) begin
        m_owner = 0; m_gap = TURN_GAP;
      end else if (TOUT != 0 && m_hold == TOUT - 1) begin
        if (m_owner == 1) set_mem = 1; else set_per = 1;
        set_flag = 1; m_owner = 0; m_gap = TURN_GAP;
      end else begin
        m_hold++;
      end
    end else if (m_gap > 0) begin
      m_gap--;
    end else begin
      mem_ok = mem_req && !m_stale_mem;
      per_ok = periph_req && !m_stale_per;
      if (!periph_req) m_starve = 0;
      if (mem_ok && (!per_ok || m_starve < STARVE)) begin
        m_owner = 1; m_hold = 0;
        if (periph_req) m_starve = (m_starve + 1 > STARVE) ? STARVE : m_starve + 1;
      end else if (per_ok) begin
        m_owner = 2; m_hold = 0; m_starve = 0;
      end
    end
    m_stale_mem = set_mem ? 1'b1 : (mem_req ? m_stale_mem : 1'b0);
    m_stale_per = set_per ? 1'b1 : (periph_req ? m_stale_per : 1'b0);
    m_flag = set_flag ? 1'b1 : (timeout_clr ? 1'b0 : m_flag);
  endtask

  // Driver: inputs are set at posedge+1, expectation queued, model steps on the next edge.
  task automatic tick();
    if (!reset_n) model_reset();
    exp_q.push_back(model_out());
    @(posedge clk);
    model_advance();
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wait_grant();
    for (int i = 0; i < 12 && !(mem_grant || periph_grant); i++) tick();
  endtask

  task automatic spot(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got %0h exp %0h at %0t", name, got, exp, $time);
    end
  endtask

  initial begin : monitor
    logic [W-1:0] exp, got;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        exp = exp_q.pop_front();
        got = {mem_grant, periph_grant, periph_blocked, owner, timeout_flag, bus_sclk, bus_mosi,
               bus_mem_cs_n, bus_periph_cs, arb_state};
        n_checks++;
        if (got !== exp) begin
          n_fail++;
          $display("FAIL scoreboard at %0t got %b exp %b", $time, got, exp);
        end
      end
    end
  end

  initial begin : guard
    #2_000_000;
    $display("FAIL global_timeout at %0t", $time);
    $fatal(1, "bench did not finish");
  end

  initial begin : stimulus
    int cnt, mem_grants;
    model_reset();
    @(posedge clk); #1;
    ticks(3);
    spot("reset_grants", 32'({mem_grant, periph_grant}), 0);
    spot("reset_owner", 32'(owner), 0);
    spot("reset_flag", 32'(timeout_flag), 0);
    spot("reset_state", 32'(arb_state), 32'(IDLE));
    reset_n = 1'b1; tick();

    // Lone peripheral request.
    periph_cs = 6'h15; periph_req = 1'b1; tick();
    spot("lone_grant", 32'(periph_grant), 1);
    spot("lone_cs_mirror", 32'(bus_periph_cs), 32'h15);
    spot("lone_mem_cs_idle", 32'(bus_mem_cs_n), 3);
    ticks(9);
    periph_req = 1'b0; tick();
    spot("lone_release", 32'({periph_grant, owner}), 0);
    tick();
    spot("lone_turn", 32'(arb_state), 32'(TURN));
    tick();
    spot("lone_idle", 32'(arb_state), 32'(IDLE));

    // Simultaneous request out of reset.
    reset_n = 1'b0; tick(); reset_n = 1'b1; tick();
    mem_req = 1'b1; periph_req = 1'b1; tick();
    spot("sim_mem_first", 32'({mem_grant, periph_grant}), 32'b10);
    ticks(4);
    mem_req = 1'b0; ticks(3);
    spot("sim_no_early_periph", 32'({mem_grant, periph_grant}), 0);
    tick();
    spot("sim_periph_after_gap", 32'(periph_grant), 1);
    periph_req = 1'b0; ticks(4);

    // Starvation: memory re-requests right after every release.
    mem_grants = 0;
    periph_req = 1'b1;
    for (int r = 0; r < 6; r++) begin
      mem_req = 1'b1;
      wait_grant();
      if (periph_grant) break;
      if (mem_grant) mem_grants++;
      ticks(2);
      mem_req = 1'b0; tick();
    end
    spot("starve_mem_grants", 32'(mem_grants), STARVE);
    spot("starve_periph_wins", 32'(periph_grant), 1);
    ticks(2);
    periph_req = 1'b0; tick();
    periph_req = 1'b1;
    wait_grant();
    spot("starve_cleared_mem_wins", 32'(mem_grant), 1);
    mem_req = 1'b0; periph_req = 1'b0; ticks(5);

    // Watchdog.
    mem_req = 1'b1;
    wait_grant();
    cnt = 0;
    while (mem_grant && cnt < 40) begin cnt++; tick(); end
    spot("wdog_hold_len", 32'(cnt), TOUT);
    spot("wdog_flag_set", 32'(timeout_flag), 1);
    ticks(6);
    spot("wdog_stale_no_regrant", 32'({mem_grant, arb_state}), 32'(IDLE));
    mem_req = 1'b0; tick();
    mem_req = 1'b1; tick();
    spot("wdog_regrant", 32'(mem_grant), 1);
    ticks(15);
    timeout_clr = 1'b1; tick();
    spot("wdog_set_beats_clr", 32'({mem_grant, timeout_flag}), 32'b01);
    timeout_clr = 1'b0; mem_req = 1'b0; tick();
    timeout_clr = 1'b1; tick();
    spot("wdog_flag_cleared", 32'(timeout_flag), 0);
    timeout_clr = 1'b0; ticks(3);

    // Idle pin levels.
    periph_cpol = 1'b1; periph_cs_idle = 6'h00; periph_cs = 6'h3f;
    mem_mosi = 1'b1; periph_mosi = 1'b1; mem_cs_n = 2'b00; mem_sclk = 1'b0; periph_sclk = 1'b0;
    tick();
    spot("idle_pins", 32'({bus_sclk, bus_mosi, bus_mem_cs_n, bus_periph_cs}), 32'b1_0_11_000000);

    // Asynchronous reset during a peripheral grant.
    periph_req = 1'b1;
    wait_grant();
    spot("rst_pre_grant", 32'(periph_grant), 1);
    reset_n = 1'b0; #1;
    spot("rst_async_grant_owner", 32'({periph_grant, owner}), 0);
    spot("rst_async_pins", 32'({bus_sclk, bus_mosi, bus_mem_cs_n, bus_periph_cs}), 32'b1_0_11_000000);
    ticks(2);
    reset_n = 1'b1; tick();
    spot("rst_fresh_grant", 32'(periph_grant), 1);
    periph_req = 1'b0; ticks(4);

    // Random traffic.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 5) == 0) mem_req = ~mem_req;
      if ($urandom_range(0, 5) == 0) periph_req = ~periph_req;
      timeout_clr = ($urandom_range(0, 15) == 0);
      reset_n = ($urandom_range(0, 499) != 0);
      mem_sclk = 1'($urandom); mem_mosi = 1'($urandom); mem_cs_n = 2'($urandom);
      periph_sclk = 1'($urandom); periph_mosi = 1'($urandom); periph_cs = 6'($urandom);
      periph_cs_idle = 6'($urandom); periph_cpol = 1'($urandom);
      tick();
    end

    @(negedge clk); #1;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain got %0d left exp 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
